// File: rtl/page_xfer_if.sv
// page_xfer_if: control handshake, page-buffer port and flash stream signals of page_xfer_engine.
// The engine connects through the master modport; the buffer/flash/host side uses slave.
interface page_xfer_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic              dir;
   logic              busy;
   logic              done;
   logic              err;
   logic              cntrl_sel;
   logic              cntrl_re;
   logic              cntrl_we;
   logic [DATA_W-1:0] cntrl_in;
   logic [DATA_W-1:0] cntrl_out;
   logic              buf_cntrl_status;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;

   modport master (
      input  start, dir, cntrl_out, buf_cntrl_status, tx_ready, rx_data, rx_valid,
      output busy, done, err, cntrl_sel, cntrl_re, cntrl_we, cntrl_in, tx_data, tx_valid
   );

   modport slave (
      output start, dir, cntrl_out, buf_cntrl_status, tx_ready, rx_data, rx_valid,
      input  busy, done, err, cntrl_sel, cntrl_re, cntrl_we, cntrl_in, tx_data, tx_valid
   );
endinterface

// File: rtl/page_xfer_engine.sv
// page_xfer_engine: moves one page between the page buffer and the flash tx/rx streams.
// Optional stall watchdog is compiled in when the macro PXE_TIMEOUT_EN is defined.
module page_xfer_engine #(
   parameter int BUF_DEPTH = 2048,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   page_xfer_if.master xfer_io
);

   localparam int            CW      = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] LAST_C  = CW'(BUF_DEPTH - 1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROG = 2'd1,
      LOAD = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     rdCnt_q, rdCnt_d;
   logic [CW-1:0]     txCnt_q, txCnt_d;
   logic [CW-1:0]     wrCnt_q, wrCnt_d;
   logic              rdPend_q, rdPend_d;
   logic [DATA_W-1:0] fifoMem_q [2];
   logic [DATA_W-1:0] fifoMem_d [2];
   logic              fifoWrPtr_q, fifoWrPtr_d;
   logic              fifoRdPtr_q, fifoRdPtr_d;
   logic [1:0]        fifoCnt_q, fifoCnt_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              statusSeen_q, statusSeen_d;

   logic              startAcc;
   logic              txValid;
   logic              txPop;
   logic              reqRe;
   logic              rxAcc;
   logic              rxBad;
   logic              lastTx;
   logic              statusWindow;
   logic              statusOk;
   logic              moved;
   logic              timeout;
   logic [2:0]        slotsUsed;

   // Read slots already claimed: entries held plus a read whose data lands this cycle, minus the entry leaving now
   assign startAcc     = (state_q == IDLE) && xfer_io.start;
   assign txValid      = (state_q == PROG) && (fifoCnt_q != 2'd0);
   assign txPop        = txValid && xfer_io.tx_ready;
   assign slotsUsed    = 3'(fifoCnt_q) + 3'(rdPend_q) - 3'(txPop);
   assign reqRe        = (state_q == PROG) && (rdCnt_q != DEPTH_C) && (slotsUsed < 3'd2);
   assign rxAcc        = (state_q == LOAD) && xfer_io.rx_valid && (wrCnt_q != DEPTH_C);
   assign rxBad        = xfer_io.rx_valid && !rxAcc;
   assign lastTx       = txPop && (txCnt_q == LAST_C);
   assign statusWindow = (state_q == PROG) && ((rdCnt_q == DEPTH_C) || (reqRe && (rdCnt_q == LAST_C)));
   assign statusOk     = statusSeen_q || (statusWindow && xfer_io.buf_cntrl_status);
   assign moved        = txPop || rxAcc;

`ifdef PXE_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);

   logic [SW-1:0] stall_q, stall_d;

   assign timeout = ((state_q == PROG) || (state_q == LOAD)) && !moved
                    && (stall_q == SW'(TIMEOUT - 1));

   // Watchdog counts consecutive cycles in a transfer state without a byte moving
   always_comb begin
      stall_d = stall_q + SW'(1);
      if (((state_q != PROG) && (state_q != LOAD)) || moved) begin
         stall_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a watchdog expiry abandons the page straight to IDLE without a done pulse
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (xfer_io.start) begin
               state_d = xfer_io.dir ? LOAD : PROG;
            end
         end
         PROG: begin
            if (lastTx) begin
               state_d = DONE;
            end
         end
         LOAD: begin
            if (wrCnt_q == DEPTH_C) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         state_d = IDLE;
      end
   end

   // Datapath next-state: read/tx/write counters, skid FIFO, write register, error and status tracking
   always_comb begin
      rdCnt_d      = rdCnt_q;
      txCnt_d      = txCnt_q;
      wrCnt_d      = wrCnt_q;
      rdPend_d     = reqRe;
      fifoMem_d    = fifoMem_q;
      fifoWrPtr_d  = fifoWrPtr_q;
      fifoRdPtr_d  = fifoRdPtr_q;
      fifoCnt_d    = fifoCnt_q;
      we_d         = rxAcc;
      wdata_d      = wdata_q;
      err_d        = err_q;
      statusSeen_d = statusOk;

      if (startAcc) begin
         rdCnt_d      = '0;
         txCnt_d      = '0;
         wrCnt_d      = '0;
         fifoWrPtr_d  = 1'b0;
         fifoRdPtr_d  = 1'b0;
         fifoCnt_d    = 2'd0;
         err_d        = 1'b0;
         statusSeen_d = 1'b0;
      end else begin
         if (reqRe) begin
            rdCnt_d = rdCnt_q + ONE_C;
         end
         if (rdPend_q) begin
            fifoMem_d[fifoWrPtr_q] = xfer_io.cntrl_out;
            fifoWrPtr_d            = ~fifoWrPtr_q;
         end
         if (txPop) begin
            fifoRdPtr_d = ~fifoRdPtr_q;
            txCnt_d     = txCnt_q + ONE_C;
         end
         fifoCnt_d = 2'(3'(fifoCnt_q) + 3'(rdPend_q) - 3'(txPop));
         if (rxAcc) begin
            wdata_d = xfer_io.rx_data;
            wrCnt_d = wrCnt_q + ONE_C;
         end
         if (lastTx && !statusOk) begin
            err_d = 1'b1;
         end
      end

      if (rxBad || timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdCnt_q      <= '0;
         txCnt_q      <= '0;
         wrCnt_q      <= '0;
         rdPend_q     <= 1'b0;
         fifoMem_q[0] <= '0;
         fifoMem_q[1] <= '0;
         fifoWrPtr_q  <= 1'b0;
         fifoRdPtr_q  <= 1'b0;
         fifoCnt_q    <= 2'd0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         statusSeen_q <= 1'b0;
      end else begin
         rdCnt_q      <= rdCnt_d;
         txCnt_q      <= txCnt_d;
         wrCnt_q      <= wrCnt_d;
         rdPend_q     <= rdPend_d;
         fifoMem_q    <= fifoMem_d;
         fifoWrPtr_q  <= fifoWrPtr_d;
         fifoRdPtr_q  <= fifoRdPtr_d;
         fifoCnt_q    <= fifoCnt_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         statusSeen_q <= statusSeen_d;
      end
   end

   // Outputs; select stays up in PROG until the final read's data has been captured
   always_comb begin
      xfer_io.busy      = (state_q != IDLE);
      xfer_io.done      = (state_q == DONE);
      xfer_io.err       = err_q;
      xfer_io.cntrl_sel = ((state_q == PROG) && ((rdCnt_q != DEPTH_C) || rdPend_q))
                          || (state_q == LOAD);
      xfer_io.cntrl_re  = reqRe;
      xfer_io.cntrl_we  = we_q;
      xfer_io.cntrl_in  = wdata_q;
      xfer_io.tx_valid  = txValid;
      xfer_io.tx_data   = txValid ? fifoMem_q[fifoRdPtr_q] : '0;
   end

endmodule
